// File: rtl/strobe_generator.sv
// Periodic one-clock strobe every PERIOD_US microseconds while Enable_i is high.
// Optional simulation-only checks are compiled in with STROBE_GENERATOR_CHECK_EN.
module strobe_generator #(
  parameter int unsigned CLOCK_HZ  = 10_000_000,
  parameter int unsigned PERIOD_US = 1000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable_i,
  output logic Strobe_o
);

  // The clock x period product overflows 32 bits for common settings, so widen first.
  localparam longint unsigned DIVIDER =
    (longint'(CLOCK_HZ) * longint'(PERIOD_US)) / 64'd1_000_000;
  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIVIDER - 64'd1);

  generate
    if (DIVIDER < 1) begin : g_bad_divider
      $error("strobe_generator: DIVIDER must be at least 1");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;

  // Disabling clears the count so re-enable always restarts a full period.
  always_comb begin
    cnt_d    = '0;
    strobe_d = 1'b0;
    if (Enable_i) begin
      if (cnt_q == TERMINAL) begin
        strobe_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign Strobe_o = strobe_q;

`ifdef STROBE_GENERATOR_CHECK_EN
  longint unsigned gap_q;
  logic            seen_q;
  logic            en_low_q;

  initial begin
    $display("strobe_generator: CLOCK_HZ=%0d PERIOD_US=%0d DIVIDER=%0d",
             CLOCK_HZ, PERIOD_US, DIVIDER);
    if (((longint'(CLOCK_HZ) * longint'(PERIOD_US)) % 64'd1_000_000) != 0)
      $warning("strobe_generator: period truncated to %0d clocks", DIVIDER);
  end

  // Spacing is measured only across an unbroken run of enabled edges.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      gap_q    <= 0;
      seen_q   <= 1'b0;
      en_low_q <= 1'b0;
    end else begin
      en_low_q <= !Enable_i;
      if (en_low_q && Strobe_o)
        $error("strobe_generator: strobe after Enable_i sampled low");
      if (!Enable_i) begin
        seen_q <= 1'b0;
        gap_q  <= 0;
      end else if (Strobe_o) begin
        if (seen_q && gap_q != DIVIDER)
          $error("strobe_generator: strobe spacing %0d, expected %0d", gap_q, DIVIDER);
        seen_q <= 1'b1;
        gap_q  <= 1;
      end else begin
        gap_q <= gap_q + 1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_strobe_generator.sv
// Bench for strobe_generator: three instances (DIVIDER 10, 1, 10000) checked every
// cycle against a run-length model of consecutive enabled edges.
module tb_strobe_generator;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] en    = 3'b000;
  logic [2:0] so;
  logic       s10, s1, s10k;

  int unsigned div_tab [3] = '{10, 1, 10000};
  int unsigned run     [3] = '{0, 0, 0};
  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  always #5 Clock = ~Clock;

  strobe_generator #(.CLOCK_HZ(10_000_000), .PERIOD_US(1)) u_d10 (
    .Clock(Clock), .Reset(Reset), .Enable_i(en[0]), .Strobe_o(s10));
  strobe_generator #(.CLOCK_HZ(1_000_000), .PERIOD_US(1)) u_d1 (
    .Clock(Clock), .Reset(Reset), .Enable_i(en[1]), .Strobe_o(s1));
  strobe_generator #(.CLOCK_HZ(10_000_000), .PERIOD_US(1000)) u_d10k (
    .Clock(Clock), .Reset(Reset), .Enable_i(en[2]), .Strobe_o(s10k));

  assign so = {s10k, s1, s10};

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // A strobe follows every edge that completes a multiple of DIVIDER consecutive enabled edges.
  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      automatic bit exp = (run[i] > 0) && ((run[i] % div_tab[i]) == 0);
      check($sformatf("strobe_div%0d", div_tab[i]), so[i], exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    for (int i = 0; i < 3; i++)
      run[i] = (!Reset || !en[i]) ? 0 : run[i] + 1;
    #1;
    compare_all();
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge Clock);
    Reset = 1'b1;

    // DIVIDER=10 for 100 enabled clocks: exactly 10 strobes; DIVIDER=1 continuous
    en[0] = 1'b1;
    en[1] = 1'b1;
    cnt = 0;
    repeat (100) begin
      step();
      if (s10) cnt++;
    end
    check("div10_strobe_count", cnt, 10);
    en[0] = 1'b0;
    en[1] = 1'b0;
    step();
    check("div1_low_after_disable", s1, 0);

    // 7 on, 3 off, re-enable: next strobe exactly 10 clocks after re-enable
    en[0] = 1'b1;
    repeat (7) step();
    en[0] = 1'b0;
    repeat (3) step();
    en[0] = 1'b1;
    cnt = 0;
    repeat (10) begin
      step();
      if (s10) cnt++;
    end
    check("reenable_one_strobe", cnt, 1);
    check("reenable_strobe_on_10th", s10, 1);

    // Drop enable on the terminal-count edge
    en[0] = 1'b0;
    step();
    en[0] = 1'b1;
    repeat (9) step();
    en[0] = 1'b0;
    step();
    check("terminal_drop_no_strobe", s10, 0);
    check("terminal_drop_cnt_zero", u_d10.cnt_q, 0);

    // Asynchronous reset mid-period with enables high
    en[0] = 1'b1;
    en[1] = 1'b1;
    repeat (5) step();
    check("d1_high_before_reset", s1, 1);
    #2 Reset = 1'b0;
    for (int i = 0; i < 3; i++) run[i] = 0;
    #1;
    compare_all();
    check("async_reset_cnt_zero", u_d10.cnt_q, 0);
    step();
    @(negedge Clock);
    Reset = 1'b1;
    repeat (12) step();

    // Randomised enable runs on the small dividers
    repeat (600) begin
      if ($urandom_range(0, 15) == 0) en[0] = ~en[0];
      if ($urandom_range(0, 7) == 0)  en[1] = ~en[1];
      step();
    end
    en[0] = 1'b0;
    en[1] = 1'b0;
    step();

    // DIVIDER=10000 for 30000 enabled clocks: strobes at 10000, 20000, 30000
    en[2] = 1'b1;
    cnt = 0;
    repeat (30000) begin
      step();
      if (s10k) cnt++;
    end
    check("div10k_strobe_count", cnt, 3);
    check("div10k_last_edge_strobe", s10k, 1);
    en[2] = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
